// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: shares the register-file write port between memory and ALU writeback and
// keeps a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module rf_wb_scheduler #(
  parameter int DATA_W = 64,
  parameter int NREG = 32,
  parameter int ZERO_REG = 31,
  parameter int STALL_W = 16,
  parameter int IW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [IW-1:0]     iss_rs1,
  input  logic [IW-1:0]     iss_rs2,
  input  logic [IW-1:0]     iss_rd,
  input  logic              iss_wr,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [IW-1:0]     alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [IW-1:0]     mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              flush,
  output logic              RegWrite,
  output logic [IW-1:0]     WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic [NREG-1:0]   busy,
  output logic              wb_err,
  output logic [STALL_W-1:0] stall_cnt
);
  logic [NREG-1:0] busy_q, busy_d, set_v, clr_v;
  logic mem_g, alu_g, wb_do, acc;
  logic [IW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  assign mem_ready = !reset;
  assign alu_ready = !reset && !mem_valid;
  assign iss_ready = !reset && !flush && !busy_q[iss_rs1] && !busy_q[iss_rs2] && !(iss_wr && busy_q[iss_rd]);
  assign busy = busy_q;
  // Busy clears only when the register file actually captures, so a dependent
  // instruction can never issue before the new value is readable.
  always_comb begin
    mem_g = mem_valid && mem_ready;
    alu_g = alu_valid && alu_ready;
    wb_rd = mem_g ? mem_rd : alu_rd;
    wb_data = mem_g ? mem_data : alu_data;
    wb_do = (mem_g || alu_g) && wb_rd != IW'(ZERO_REG) && !flush;
    acc = iss_valid && iss_ready;
    set_v = (acc && iss_wr && iss_rd != IW'(ZERO_REG)) ? NREG'(1) << iss_rd : '0;
    clr_v = RegWrite ? NREG'(1) << WriteRegister : '0;
    busy_d = flush ? '0 : (busy_q & ~clr_v) | set_v;
    busy_d[ZERO_REG] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      RegWrite <= 1'b0;
      WriteRegister <= '0;
      WriteData <= '0;
      wb_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      busy_q <= busy_d;
      RegWrite <= wb_do;
      if (wb_do) begin
        WriteRegister <= wb_rd;
        WriteData <= wb_data;
      end
      if (wb_do && !busy_q[wb_rd]) wb_err <= 1'b1;
      if (iss_valid && !iss_ready && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler: directed and randomized checks against a cycle-level reference model.
module tb_rf_wb_scheduler;
  logic clk = 1'b0, reset = 1'b1;
  logic iss_valid = 0, iss_wr = 0, alu_valid = 0, mem_valid = 0, flush = 0;
  logic [4:0] iss_rs1 = 0, iss_rs2 = 0, iss_rd = 0, alu_rd = 0, mem_rd = 0;
  logic [63:0] alu_data = 0, mem_data = 0;
  logic iss_ready, alu_ready, mem_ready, RegWrite, wb_err;
  logic [4:0] WriteRegister;
  logic [63:0] WriteData;
  logic [31:0] busy;
  logic [15:0] stall_cnt;
  int checks = 0, errors = 0;
  logic [31:0] mb = '0;
  logic m_rw = 0, m_err = 0;
  logic [4:0] m_wr = 0;
  logic [63:0] m_wd = 0;
  int m_stall = 0;
  logic alu_hold = 0;

  rf_wb_scheduler dut (
    .clk(clk), .reset(reset), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_wr(iss_wr),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .flush(flush), .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .busy(busy), .wb_err(wb_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model, check registered outputs after the edge.
  task automatic step();
    logic er, g;
    logic [31:0] nb;
    logic [4:0] grd;
    logic [63:0] gd;
    @(negedge clk);
    er = !reset && !flush && !mb[iss_rs1] && !mb[iss_rs2] && !(iss_wr && mb[iss_rd]);
    chk("iss_ready", iss_ready, er);
    chk("mem_ready", mem_ready, !reset);
    chk("alu_ready", alu_ready, !reset && !mem_valid);
    chk("busy", busy, mb);
    if (reset) begin
      mb = '0; m_rw = 0; m_wr = 0; m_wd = 0; m_err = 0; m_stall = 0;
    end else begin
      nb = mb;
      if (m_rw) nb[m_wr] = 1'b0;
      if (flush) nb = '0;
      if (iss_valid && er && iss_wr && iss_rd != 31) nb[iss_rd] = 1'b1;
      g = mem_valid || alu_valid;
      grd = mem_valid ? mem_rd : alu_rd;
      gd = mem_valid ? mem_data : alu_data;
      if (iss_valid && !er && !flush && m_stall < 65535) m_stall++;
      if (g && grd != 31 && !flush) begin
        if (!mb[grd]) m_err = 1'b1;
        m_rw = 1'b1; m_wr = grd; m_wd = gd;
      end else m_rw = 1'b0;
      mb = nb;
    end
    @(posedge clk);
    #1;
    chk("RegWrite", RegWrite, m_rw);
    chk("WriteRegister", WriteRegister, m_wr);
    chk("WriteData", WriteData, m_wd);
    chk("wb_err", wb_err, m_err);
    chk("stall_cnt", stall_cnt, 64'(m_stall));
  endtask

  task automatic idle();
    iss_valid = 0; iss_wr = 0; alu_valid = 0; mem_valid = 0; flush = 0; reset = 0;
  endtask

  function automatic logic [4:0] pick();
    return ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    step(); step();
    reset = 0;
    iss_valid = 0; iss_rs1 = 5'd13; iss_rs2 = 5'd31; iss_rd = 5'd7; iss_wr = 1;
    step();
    chk("idle_busy", busy, 0);
    chk("idle_stall", stall_cnt, 0);
    // RAW: issue X5 writer, stall a reader of X5 until the ALU result commits
    idle(); iss_valid = 1; iss_wr = 1; iss_rd = 5; iss_rs1 = 0; iss_rs2 = 0;
    step();
    chk("busy5_set", busy[5], 1);
    iss_wr = 0; iss_rs1 = 5; iss_rd = 0;
    alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
    step();
    chk("raw_regwrite", RegWrite, 1);
    chk("raw_wreg", WriteRegister, 5);
    chk("raw_wdata", WriteData, 64'h1234);
    alu_valid = 0;
    step();
    step();
    chk("raw_stalls", stall_cnt, 2);
    chk("raw_busy_clear", busy[5], 0);
    // Both sources at once: memory wins, ALU holds for one cycle
    idle(); iss_valid = 1; iss_wr = 1; iss_rd = 3; iss_rs1 = 0; iss_rs2 = 0;
    step();
    iss_rd = 4;
    step();
    idle(); mem_valid = 1; mem_rd = 3; mem_data = 64'hAAAA; alu_valid = 1; alu_rd = 4; alu_data = 64'hBBBB;
    step();
    chk("arb_mem_first", WriteRegister, 3);
    mem_valid = 0;
    step();
    chk("arb_alu_next", WriteData, 64'hBBBB);
    alu_valid = 0;
    step(); step();
    // Zero register is never busy and never written
    idle(); iss_valid = 1; iss_wr = 1; iss_rd = 31;
    step();
    idle(); mem_valid = 1; mem_rd = 31; mem_data = 64'hFF;
    step();
    chk("x31_busy", busy, 0);
    chk("x31_regwrite", RegWrite, 0);
    chk("x31_err", wb_err, 0);
    // Writeback to a non-busy register is performed and flagged
    idle(); alu_valid = 1; alu_rd = 7; alu_data = 64'h77;
    step();
    chk("err_set", wb_err, 1);
    chk("err_write", WriteRegister, 7);
    idle(); step(); step();
    chk("err_sticky", wb_err, 1);
    // Flush clears the scoreboard and discards the in-flight writeback
    reset = 1; step(); idle();
    iss_valid = 1; iss_wr = 1; iss_rd = 2; step();
    iss_rd = 9; step();
    chk("pre_flush_busy", busy, 32'h0000_0204);
    idle(); flush = 1; iss_valid = 1; alu_valid = 1; alu_rd = 2; alu_data = 64'h22;
    #2 chk("flush_ready", iss_ready, 0);
    step();
    chk("flush_busy", busy, 0);
    chk("flush_regwrite", RegWrite, 0);
    idle(); step();
    // Randomized traffic; an ungranted ALU result is held until accepted
    for (int c = 0; c < 500; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 19) == 0);
      iss_valid = 1'($urandom_range(0, 1)); iss_wr = 1'($urandom_range(0, 1));
      iss_rs1 = pick(); iss_rs2 = pick(); iss_rd = pick();
      mem_valid = ($urandom_range(0, 2) == 0); mem_rd = pick(); mem_data = {$urandom, $urandom};
      if (!alu_hold) begin
        alu_valid = 1'($urandom_range(0, 1)); alu_rd = pick(); alu_data = {$urandom, $urandom};
      end
      alu_hold = alu_valid && mem_valid && !reset;
      step();
    end
    // Saturate the stall counter
    idle(); reset = 1; step(); idle();
    iss_valid = 1; iss_wr = 1; iss_rd = 1; iss_rs1 = 0; iss_rs2 = 0; step();
    iss_wr = 0; iss_rs1 = 1;
    for (int c = 0; c < 65540; c++) step();
    chk("stall_sat", stall_cnt, 16'hFFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
